// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// The master drives the decode fields; the slave answers with stall/forward.
interface hazard_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 2
);
    logic              d_valid;
    logic [ADDR_W-1:0] d_rs;
    logic [ADDR_W-1:0] d_rt;
    logic              d_rs_req;
    logic              d_rt_req;
    logic [LAT_W-1:0]  d_rs_use;
    logic [LAT_W-1:0]  d_rt_use;
    logic [ADDR_W-1:0] d_dst;
    logic [LAT_W-1:0]  d_dst_ready;
    logic              ext_stall;
    logic              flush;
    logic              stall;
    logic [LAT_W-1:0]  rs_fwd;
    logic [LAT_W-1:0]  rt_fwd;
    logic [LAT_W-1:0]  inflight;
    logic [31:0]       stall_count;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_req, d_rt_req,
        output d_rs_use, d_rt_use, d_dst, d_dst_ready,
        output ext_stall, flush,
        input  stall, rs_fwd, rt_fwd, inflight, stall_count
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_req, d_rt_req,
        input  d_rs_use, d_rt_use, d_dst, d_dst_ready,
        input  ext_stall, flush,
        output stall, rs_fwd, rt_fwd, inflight, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the post-decode pipe (stages 1..STAGES).
// Optional macro SCOREBOARD_FWD_EN enables bypass forwarding.
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);

    logic [STAGES:1]              v_q, v_d;
    logic [STAGES:1][ADDR_W-1:0]  dst_q, dst_d;
    logic [STAGES:1][LAT_W-1:0]   rdy_q, rdy_d;
    logic [LAT_W-1:0]             cnt_q, cnt_d;
    logic [31:0]                  sc_q, sc_d;

    logic             rs_hit, rt_hit;
    logic [LAT_W-1:0] rs_k, rt_k;
    logic [LAT_W-1:0] rs_rdy, rt_rdy;
    logic             stall_rs, stall_rt;
    logic             stall;
    logic [LAT_W-1:0] rs_fwd, rt_fwd;

    // Find the youngest (lowest stage) in-flight producer of each source.
    always_comb begin
        rs_hit = 1'b0;
        rs_k   = '0;
        rs_rdy = '0;
        rt_hit = 1'b0;
        rt_k   = '0;
        rt_rdy = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (v_q[k] && sb.d_rs_req && (sb.d_rs != '0) &&
                (dst_q[k] == sb.d_rs)) begin
                rs_hit = 1'b1;
                rs_k   = LAT_W'(k);
                rs_rdy = rdy_q[k];
            end
            if (v_q[k] && sb.d_rt_req && (sb.d_rt != '0) &&
                (dst_q[k] == sb.d_rt)) begin
                rt_hit = 1'b1;
                rt_k   = LAT_W'(k);
                rt_rdy = rdy_q[k];
            end
        end
    end

`ifdef SCOREBOARD_FWD_EN
    // Result is usable once its ready stage is no later than the consumer's.
    logic [LAT_W:0] rs_need, rt_need;

    assign rs_need  = {1'b0, rs_k} + {1'b0, sb.d_rs_use};
    assign rt_need  = {1'b0, rt_k} + {1'b0, sb.d_rt_use};
    assign stall_rs = rs_hit && ({1'b0, rs_rdy} > rs_need);
    assign stall_rt = rt_hit && ({1'b0, rt_rdy} > rt_need);
    assign rs_fwd   = (rs_hit && !stall_rs) ? rs_k : '0;
    assign rt_fwd   = (rt_hit && !stall_rt) ? rt_k : '0;
`else
    // Without bypass, wait until the producer reaches the write-through stage.
    logic unused_fwd;

    assign stall_rs   = rs_hit && (rs_k != LAT_W'(STAGES));
    assign stall_rt   = rt_hit && (rt_k != LAT_W'(STAGES));
    assign rs_fwd     = '0;
    assign rt_fwd     = '0;
    assign unused_fwd = ^{rs_rdy, rt_rdy, sb.d_rs_use, sb.d_rt_use};
`endif

    assign stall = sb.d_valid && (stall_rs || stall_rt) && !sb.flush;

    // Next state: flush beats freeze, freeze beats shift/insert.
    always_comb begin
        v_d   = v_q;
        dst_d = dst_q;
        rdy_d = rdy_q;
        sc_d  = sc_q;
        if (stall && !sb.ext_stall && (sc_q != '1)) begin
            sc_d = sc_q + 32'd1;
        end
        if (sb.flush) begin
            v_d = '0;
        end else if (!sb.ext_stall) begin
            for (int k = STAGES; k >= 2; k--) begin
                v_d[k]   = v_q[k-1];
                dst_d[k] = dst_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            v_d[1]   = sb.d_valid && !stall && (sb.d_dst != '0);
            dst_d[1] = sb.d_dst;
            rdy_d[1] = sb.d_dst_ready;
        end
        cnt_d = '0;
        for (int k = 1; k <= STAGES; k++) begin
            cnt_d = cnt_d + LAT_W'(v_d[k]);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q   <= '0;
            dst_q <= '0;
            rdy_q <= '0;
            cnt_q <= '0;
            sc_q  <= '0;
        end else begin
            v_q   <= v_d;
            dst_q <= dst_d;
            rdy_q <= rdy_d;
            cnt_q <= cnt_d;
            sc_q  <= sc_d;
        end
    end

    assign sb.stall       = stall;
    assign sb.rs_fwd      = rs_fwd;
    assign sb.rt_fwd      = rt_fwd;
    assign sb.inflight    = cnt_q;
    assign sb.stall_count = sc_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: queue-based model plus directed literals.
// Works with or without SCOREBOARD_FWD_EN defined.
module tb_hazard_scoreboard;
    localparam int S  = 3;
    localparam int AW = 5;
    localparam int LW = 2;
`ifdef SCOREBOARD_FWD_EN
    localparam int SC_A = 0;
    localparam int SC_B = 1;
`else
    localparam int SC_A = 2;
    localparam int SC_B = 4;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STAGES(S), .ADDR_W(AW), .LAT_W(LW)) sb ();

    hazard_scoreboard #(.STAGES(S), .ADDR_W(AW), .LAT_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Model: list of in-flight producers tagged with their current stage.
    typedef struct {
        int dst;
        int rdy;
        int age;
    } rec_t;

    rec_t        pipe[$];
    logic [31:0] m_sc = '0;
    bit          live = 1'b0;

    function automatic void m_src(input int x, input bit req, input int use_,
                                  output bit st, output int fwd);
        int best;
        int rdy;
        best = 0;
        rdy  = 0;
        st   = 1'b0;
        fwd  = 0;
        foreach (pipe[i]) begin
            if (req && x != 0 && pipe[i].dst == x &&
                (best == 0 || pipe[i].age < best)) begin
                best = pipe[i].age;
                rdy  = pipe[i].rdy;
            end
        end
        if (best != 0) begin
`ifdef SCOREBOARD_FWD_EN
            st  = rdy > best + use_;
            fwd = st ? 0 : best;
`else
            st  = best < S;
            fwd = 0;
`endif
        end
    endfunction

    function automatic bit m_stall();
        bit a;
        bit b;
        int f;
        m_src(int'(sb.d_rs), sb.d_rs_req, int'(sb.d_rs_use), a, f);
        m_src(int'(sb.d_rt), sb.d_rt_req, int'(sb.d_rt_use), b, f);
        return sb.d_valid && (a || b) && !sb.flush;
    endfunction

    always @(posedge clk) begin : model
        bit   st;
        rec_t nq[$];
        st = m_stall();
        nq.delete();
        if (!reset) begin
            pipe.delete();
            m_sc = '0;
            live = 1'b1;
        end else begin
            if (st && !sb.ext_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (sb.flush) begin
                pipe.delete();
            end else if (!sb.ext_stall) begin
                foreach (pipe[i]) begin
                    if (pipe[i].age < S)
                        nq.push_back('{pipe[i].dst, pipe[i].rdy, pipe[i].age + 1});
                end
                if (sb.d_valid && !st && sb.d_dst != 0)
                    nq.push_back('{int'(sb.d_dst), int'(sb.d_dst_ready), 1});
                pipe = nq;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit a;
        bit b;
        int fr;
        int ft;
        if (live) begin
            m_src(int'(sb.d_rs), sb.d_rs_req, int'(sb.d_rs_use), a, fr);
            m_src(int'(sb.d_rt), sb.d_rt_req, int'(sb.d_rt_use), b, ft);
            chk("m_stall", sb.stall, m_stall());
            chk("m_rs_fwd", sb.rs_fwd, fr);
            chk("m_rt_fwd", sb.rt_fwd, ft);
            chk("m_inflight", sb.inflight, pipe.size());
            chk("m_stall_count", sb.stall_count, m_sc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle();
        sb.d_valid     = 1'b0;
        sb.d_rs        = '0;
        sb.d_rt        = '0;
        sb.d_rs_req    = 1'b0;
        sb.d_rt_req    = 1'b0;
        sb.d_rs_use    = '0;
        sb.d_rt_use    = '0;
        sb.d_dst       = '0;
        sb.d_dst_ready = '0;
        sb.ext_stall   = 1'b0;
        sb.flush       = 1'b0;
    endtask

    task automatic issue(input int dst, input int rdy);
        idle();
        sb.d_valid     = 1'b1;
        sb.d_dst       = AW'(dst);
        sb.d_dst_ready = LW'(rdy);
    endtask

    task automatic use_rs(input int r, input int u);
        idle();
        sb.d_valid  = 1'b1;
        sb.d_rs     = AW'(r);
        sb.d_rs_req = 1'b1;
        sb.d_rs_use = LW'(u);
    endtask

    task automatic apply(input int v, input int rs, input int rsq, input int rsu,
                         input int rt, input int rtq, input int rtu,
                         input int dst, input int rdy, input int ex, input int fl);
        sb.d_valid     = v[0];
        sb.d_rs        = AW'(rs);
        sb.d_rs_req    = rsq[0];
        sb.d_rs_use    = LW'(rsu);
        sb.d_rt        = AW'(rt);
        sb.d_rt_req    = rtq[0];
        sb.d_rt_use    = LW'(rtu);
        sb.d_dst       = AW'(dst);
        sb.d_dst_ready = LW'(rdy);
        sb.ext_stall   = ex[0];
        sb.flush       = fl[0];
        look();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
        look();
        chk("rst_inflight", sb.inflight, 0);
        chk("rst_stall_count", sb.stall_count, 0);
        chk("rst_stall", sb.stall, 0);
        chk("rst_rs_fwd", sb.rs_fwd, 0);

        // ALU producer followed by a dependent consumer
        issue(8, 2);
        tick();
        use_rs(8, 1);
        look();
`ifdef SCOREBOARD_FWD_EN
        chk("alu_stall", sb.stall, 0);
        chk("alu_rs_fwd", sb.rs_fwd, 1);
        tick();
`else
        chk("nofwd_stall1", sb.stall, 1);
        tick();
        look();
        chk("nofwd_stall2", sb.stall, 1);
        tick();
        look();
        chk("nofwd_release", sb.stall, 0);
        chk("nofwd_rs_fwd", sb.rs_fwd, 0);
        tick();
`endif
        idle();
        repeat (3) tick();
        look();
        chk("alu_drain_inflight", sb.inflight, 0);
        chk("alu_stall_count", sb.stall_count, SC_A);

        // load-use
        issue(9, 3);
        tick();
        use_rs(9, 1);
        look();
        chk("ld_stall1", sb.stall, 1);
        tick();
        look();
`ifdef SCOREBOARD_FWD_EN
        chk("ld_release", sb.stall, 0);
        chk("ld_rs_fwd", sb.rs_fwd, 2);
`else
        chk("ld_stall2", sb.stall, 1);
        tick();
        look();
        chk("ld_release", sb.stall, 0);
        chk("ld_rs_fwd", sb.rs_fwd, 0);
`endif
        chk("ld_stall_count", sb.stall_count, SC_B);
        tick();
        idle();
        repeat (3) tick();

        // r0 is never tracked
        issue(0, 2);
        tick();
        use_rs(0, 0);
        look();
        chk("r0_stall", sb.stall, 0);
        chk("r0_rs_fwd", sb.rs_fwd, 0);
        chk("r0_inflight", sb.inflight, 0);
        tick();
        idle();
        repeat (3) tick();
        look();
        chk("r0_drain_inflight", sb.inflight, 0);

        // load-use held under an external freeze
        issue(9, 3);
        tick();
        use_rs(9, 1);
        look();
        chk("frz_stall0", sb.stall, 1);
        chk("frz_inflight0", sb.inflight, 1);
        sb.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            look();
            chk("frz_inflight", sb.inflight, 1);
            chk("frz_stall_count", sb.stall_count, SC_B);
            chk("frz_stall", sb.stall, 1);
        end

        // flush kills the stall and the entries
        sb.ext_stall = 1'b0;
        sb.flush     = 1'b1;
        #1;
        chk("fl_stall_now", sb.stall, 0);
        tick();
        sb.flush = 1'b0;
        look();
        chk("fl_inflight", sb.inflight, 0);
        chk("fl_stall", sb.stall, 0);
        chk("fl_stall_count", sb.stall_count, SC_B);

        // reset together with flush and freeze
        issue(9, 3);
        tick();
        use_rs(9, 1);
        look();
        chk("rf_stall0", sb.stall, 1);
        sb.flush     = 1'b1;
        sb.ext_stall = 1'b1;
        reset        = 1'b0;
        tick();
        look();
        chk("rf_stall_count", sb.stall_count, 0);
        chk("rf_inflight", sb.inflight, 0);
        chk("rf_stall", sb.stall, 0);
        reset = 1'b1;
        idle();
        tick();

        // youngest producer wins, checked on the rt port
        issue(5, 1);
        tick();
        issue(5, 2);
        tick();
        idle();
        sb.d_valid     = 1'b1;
        sb.d_rt        = 5'd5;
        sb.d_rt_req    = 1'b1;
        sb.d_rt_use    = 2'd1;
        sb.d_rs        = 5'd5;
        sb.d_dst       = 5'd6;
        sb.d_dst_ready = 2'd2;
        look();
`ifdef SCOREBOARD_FWD_EN
        chk("yng_stall", sb.stall, 0);
        chk("yng_rt_fwd", sb.rt_fwd, 1);
`else
        chk("yng_stall", sb.stall, 1);
        chk("yng_rt_fwd", sb.rt_fwd, 0);
`endif
        chk("yng_rs_fwd", sb.rs_fwd, 0);
        tick();

        // mixed vectors, checked by the model
        apply(1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        apply(1, 3, 1, 0, 4, 1, 1, 4, 2, 0, 0);
        apply(1, 3, 1, 0, 4, 1, 1, 4, 2, 0, 0);
        apply(1, 3, 1, 0, 4, 1, 1, 4, 2, 0, 0);
        apply(1, 4, 1, 1, 3, 1, 2, 7, 1, 0, 0);
        apply(1, 7, 1, 0, 7, 1, 0, 2, 2, 1, 0);
        apply(1, 7, 1, 0, 7, 1, 0, 2, 2, 0, 0);
        apply(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 2, 1, 1, 2, 0, 0, 2, 3, 0, 1);
        apply(1, 31, 1, 3, 31, 1, 0, 31, 3, 0, 0);
        apply(1, 31, 1, 0, 31, 1, 3, 0, 0, 0, 0);
        apply(1, 31, 1, 0, 31, 1, 3, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (4) tick();
        look();
        chk("end_inflight", sb.inflight, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
